// File: rtl/clk_reset_sequencer_if.sv
// Board reset sequencer signal bundle: PLL lock / button / debug request
// inputs and the reset, status and diagnostic outputs.
interface clk_reset_sequencer_if #(
   parameter int N_PLL = 2
);
   logic [N_PLL-1:0] pll_locked;
   logic             button_n;
   logic             sw_reset_req;
   logic             pll_reset;
   logic             sys_areset;
   logic [1:0]       state;
   logic [3:0]       reset_cause;
   logic [7:0]       retry_count;

   // Sequencer side: consumes lock/button/request, drives resets and status.
   modport master (
      input  pll_locked, button_n, sw_reset_req,
      output pll_reset, sys_areset, state, reset_cause, retry_count
   );

   // Board side: drives lock/button/request, observes resets and status.
   modport slave (
      output pll_locked, button_n, sw_reset_req,
      input  pll_reset, sys_areset, state, reset_cause, retry_count
   );
endinterface

// File: rtl/clk_reset_sequencer.sv
// Board-level reset sequencer on the free-running oscillator: resets the
// PLLs, waits for stable lock, holds the system reset for a minimum time,
// then watches for lock loss, push-button and debug reset requests.
module clk_reset_sequencer #(
   parameter int N_PLL          = 2,
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_STABLE    = 1024,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int HOLD_CYCLES    = 256,
   parameter int BTN_STABLE     = 65536
) (
   input logic                   clock,
   input logic                   areset,
   clk_reset_sequencer_if.master bus
);
   localparam int PW = $clog2(PLL_RST_CYCLES) + 1;
   localparam int LW = $clog2(LOCK_STABLE) + 1;
   localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
   localparam int HW = $clog2(HOLD_CYCLES) + 1;
   localparam int BW = $clog2(BTN_STABLE) + 1;

   typedef enum logic [1:0] {
      PLL_RESET = 2'd0,
      WAIT_LOCK = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } state_t;

   logic [1:0]       rst_sync_q;
   logic             rst_hold;
   logic [N_PLL-1:0] lock_s0_q, lock_s1_q;
   logic             all_locked;
   logic             btn_s0_q, btn_s1_q;
   logic             btn_lvl;
   logic             btn_dn_q, btn_dn_d;
   logic [BW-1:0]    btn_cnt_q, btn_cnt_d;
   logic             btn_press_q, btn_press_d;
   state_t           state_q, state_d;
   logic [PW-1:0]    pcnt_q, pcnt_d;
   logic [LW-1:0]    stab_q, stab_d;
   logic [TW-1:0]    tout_q, tout_d;
   logic [HW-1:0]    hcnt_q, hcnt_d;
   logic [3:0]       cause_q, cause_d;
   logic [7:0]       retry_q, retry_d;
   logic             pll_reset_q, sys_areset_q;

   // Release synchronizer: areset asserts at once, deasserts after two edges.
   always_ff @(posedge clock or posedge areset) begin
      if (areset) rst_sync_q <= 2'b11;
      else        rst_sync_q <= {rst_sync_q[0], 1'b0};
   end
   assign rst_hold = rst_sync_q[1];

   // Lock synchronizers; lock is meaningless while the PLLs are held in reset,
   // so the chain is flushed then and must refill after pll_reset drops.
   always_ff @(posedge clock or posedge areset) begin
      if (areset || pll_reset_q) begin
         lock_s0_q <= '0;
         lock_s1_q <= '0;
      end else begin
         lock_s0_q <= bus.pll_locked;
         lock_s1_q <= lock_s0_q;
      end
   end
   assign all_locked = &lock_s1_q;

   // Button synchronizer, resets to released.
   always_ff @(posedge clock or posedge areset) begin
      if (areset) begin
         btn_s0_q <= 1'b1;
         btn_s1_q <= 1'b1;
      end else begin
         btn_s0_q <= bus.button_n;
         btn_s1_q <= btn_s0_q;
      end
   end
   assign btn_lvl = ~btn_s1_q;

   // Debouncer: flip the debounced level after BTN_STABLE disagreeing cycles;
   // a press pulse fires only on the released->pressed flip.
   always_comb begin
      btn_dn_d    = btn_dn_q;
      btn_cnt_d   = '0;
      btn_press_d = 1'b0;
      if (btn_lvl != btn_dn_q) begin
         if (btn_cnt_q == BW'(BTN_STABLE - 1)) begin
            btn_dn_d    = btn_lvl;
            btn_press_d = btn_lvl;
         end else begin
            btn_cnt_d = btn_cnt_q + 1'b1;
         end
      end
   end

   // Debouncer state register.
   always_ff @(posedge clock or posedge areset) begin
      if (areset) begin
         btn_dn_q    <= 1'b0;
         btn_cnt_q   <= '0;
         btn_press_q <= 1'b0;
      end else begin
         btn_dn_q    <= btn_dn_d;
         btn_cnt_q   <= btn_cnt_d;
         btn_press_q <= btn_press_d;
      end
   end

   // Sequencer next-state, counters and cause/retry bookkeeping.
   always_comb begin
      state_d = state_q;
      pcnt_d  = '0;
      stab_d  = '0;
      tout_d  = '0;
      hcnt_d  = '0;
      cause_d = cause_q;
      retry_d = retry_q;
      unique case (state_q)
         PLL_RESET: begin
            if (pcnt_q == PW'(PLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
            else                                   pcnt_d  = pcnt_q + 1'b1;
         end
         WAIT_LOCK: begin
            stab_d = all_locked ? stab_q + 1'b1 : '0;
            tout_d = tout_q + 1'b1;
            // Lock acceptance is tested first so it wins a same-cycle timeout.
            if (stab_d == LW'(LOCK_STABLE)) begin
               state_d = HOLD;
               stab_d  = '0;
               tout_d  = '0;
            end else if (tout_d == TW'(LOCK_TIMEOUT)) begin
               state_d = PLL_RESET;
               stab_d  = '0;
               tout_d  = '0;
               if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
            end
         end
         HOLD: begin
            if (!all_locked) begin
               state_d = PLL_RESET;
               cause_d = 4'b0010;
            end else if (btn_press_q || bus.sw_reset_req) begin
               cause_d = cause_q | {bus.sw_reset_req, btn_press_q, 2'b00};
            end else if (hcnt_q == HW'(HOLD_CYCLES - 1)) begin
               state_d = RUN;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!all_locked || btn_press_q || bus.sw_reset_req)
               cause_d = {bus.sw_reset_req, btn_press_q, ~all_locked, 1'b0};
            if (!all_locked || btn_press_q) state_d = PLL_RESET;
            else if (bus.sw_reset_req)      state_d = HOLD;
         end
         default: state_d = PLL_RESET;
      endcase
      // Until the release synchronizer clears, hold everything at power-on values.
      if (rst_hold) begin
         state_d = PLL_RESET;
         pcnt_d  = '0;
         stab_d  = '0;
         tout_d  = '0;
         hcnt_d  = '0;
         cause_d = 4'b0001;
         retry_d = '0;
      end
   end

   // Sequencer registers; outputs are registered from the next state.
   always_ff @(posedge clock or posedge areset) begin
      if (areset) begin
         state_q      <= PLL_RESET;
         pcnt_q       <= '0;
         stab_q       <= '0;
         tout_q       <= '0;
         hcnt_q       <= '0;
         cause_q      <= 4'b0001;
         retry_q      <= '0;
         pll_reset_q  <= 1'b1;
         sys_areset_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         pcnt_q       <= pcnt_d;
         stab_q       <= stab_d;
         tout_q       <= tout_d;
         hcnt_q       <= hcnt_d;
         cause_q      <= cause_d;
         retry_q      <= retry_d;
         pll_reset_q  <= (state_d == PLL_RESET);
         sys_areset_q <= (state_d != RUN);
      end
   end

   assign bus.pll_reset   = pll_reset_q;
   assign bus.sys_areset  = sys_areset_q;
   assign bus.state       = state_q;
   assign bus.reset_cause = cause_q;
   assign bus.retry_count = retry_q;
endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Self-checking bench for clk_reset_sequencer with shortened timing parameters.
module tb_clk_reset_sequencer;
   localparam int P_RST = 4;
   localparam int L_ST  = 8;
   localparam int L_TO  = 32;
   localparam int H_C   = 6;
   localparam int B_ST  = 4;

   logic clock = 1'b0;
   logic areset;
   int   checks = 0;
   int   failures = 0;
   logic [1:0] pat [L_TO];

   clk_reset_sequencer_if #(.N_PLL(2)) bus ();

   clk_reset_sequencer #(
      .N_PLL(2), .PLL_RST_CYCLES(P_RST), .LOCK_STABLE(L_ST),
      .LOCK_TIMEOUT(L_TO), .HOLD_CYCLES(H_C), .BTN_STABLE(B_ST)
   ) dut (
      .clock (clock),
      .areset(areset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Expected state d cycles after entering PLL_RESET with locks solid:
   // reset pulse, 2-cycle lock resync, stable window, hold window, run.
   function automatic logic [1:0] por_state(input int d);
      if (d < P_RST)                  return 2'd0;
      if (d < P_RST + 2 + L_ST)       return 2'd1;
      if (d < P_RST + 2 + L_ST + H_C) return 2'd2;
      return 2'd3;
   endfunction

   // Cycle m of WAIT_LOCK (m=1 first) sees pat[m-3] through the resync;
   // returns the cycle the state leaves WAIT_LOCK and whether lock was taken.
   function automatic int model_wait(output bit got);
      int run = 0;
      got = 1'b0;
      for (int m = 1; m <= L_TO; m++) begin
         if (m >= 3 && pat[m-3] == 2'b11) run++;
         else                             run = 0;
         if (run == L_ST) begin
            got = 1'b1;
            return m;
         end
      end
      return L_TO;
   endfunction

   task automatic wait_pll_fall(output int n);
      n = 0;
      while (bus.pll_reset !== 1'b0 && n < 200) begin
         tick();
         n++;
      end
      if (bus.pll_reset !== 1'b0) begin
         checks++;
         failures++;
         $display("FAIL pll_reset_fall_timeout got=%b exp=0", bus.pll_reset);
      end
   endtask

   task automatic do_por(input logic [1:0] lk);
      int n;
      bus.pll_locked   = lk;
      bus.button_n     = 1'b1;
      bus.sw_reset_req = 1'b0;
      areset = 1'b1;
      tick();
      tick();
      areset = 1'b0;
      wait_pll_fall(n);
      checks++;
      if (n != 2 + P_RST) begin
         failures++;
         $display("FAIL por_release_latency got=%0d exp=%0d", n, 2 + P_RST);
      end
   endtask

   task automatic test_reset();
      logic [1:0] es;
      bus.pll_locked   = 2'b11;
      bus.button_n     = 1'b1;
      bus.sw_reset_req = 1'b0;
      areset = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      checks += 5;
      if (bus.pll_reset !== 1'b1) begin failures++; $display("FAIL rst_pll_reset got=%b exp=1", bus.pll_reset); end
      if (bus.sys_areset !== 1'b1) begin failures++; $display("FAIL rst_sys_areset got=%b exp=1", bus.sys_areset); end
      if (bus.state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", bus.state); end
      if (bus.reset_cause !== 4'b0001) begin failures++; $display("FAIL rst_cause got=%b exp=0001", bus.reset_cause); end
      if (bus.retry_count !== 8'd0) begin failures++; $display("FAIL rst_retry got=%0d exp=0", bus.retry_count); end
      areset = 1'b0;
      // Internal release lands on the 2nd edge; the sequence counts from there.
      for (int k = 1; k <= 26; k++) begin
         tick();
         es = (k < 2) ? 2'd0 : por_state(k - 2);
         checks += 3;
         if (bus.state !== es) begin failures++; $display("FAIL por_state k=%0d got=%0d exp=%0d", k, bus.state, es); end
         if (bus.pll_reset !== (es == 2'd0)) begin failures++; $display("FAIL por_pll_reset k=%0d got=%b exp=%b", k, bus.pll_reset, es == 2'd0); end
         if (bus.sys_areset !== (es != 2'd3)) begin failures++; $display("FAIL por_sys_areset k=%0d got=%b exp=%b", k, bus.sys_areset, es != 2'd3); end
      end
      checks++;
      if (bus.reset_cause !== 4'b0001) begin failures++; $display("FAIL por_cause got=%b exp=0001", bus.reset_cause); end
   endtask

   task automatic test_lock_chatter();
      int mexp;
      bit got;
      logic [1:0] es;
      for (int trial = 0; trial < 10; trial++) begin
         for (int i = 0; i < L_TO; i++) begin
            if (trial == 0)      pat[i] = 2'b11;
            else if (trial == 1) pat[i] = (i == 7) ? 2'b01 : 2'b11;
            else                 pat[i] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
         end
         mexp = model_wait(got);
         do_por(2'b11);
         for (int m = 1; m <= mexp; m++) begin
            bus.pll_locked = pat[m-1];
            tick();
            es = (m < mexp) ? 2'd1 : (got ? 2'd2 : 2'd0);
            checks++;
            if (bus.state !== es) begin
               failures++;
               $display("FAIL chatter_state trial=%0d m=%0d got=%0d exp=%0d", trial, m, bus.state, es);
            end
         end
         checks++;
         if (bus.retry_count !== (got ? 8'd0 : 8'd1)) begin
            failures++;
            $display("FAIL chatter_retry trial=%0d got=%0d exp=%0d", trial, bus.retry_count, got ? 0 : 1);
         end
         bus.pll_locked = 2'b11;
      end
   endtask

   task automatic test_lock_timeout();
      int n;
      int er;
      do_por(2'b01);
      for (int i = 1; i <= 300; i++) begin
         for (int t = 1; t <= L_TO; t++) begin
            tick();
            if (t >= L_TO - 1) begin
               checks++;
               if (bus.pll_reset !== (t == L_TO)) begin
                  failures++;
                  $display("FAIL timeout_pll_reset i=%0d t=%0d got=%b exp=%b", i, t, bus.pll_reset, t == L_TO);
               end
            end
         end
         er = (i > 255) ? 255 : i;
         checks++;
         if (bus.retry_count !== 8'(er)) begin
            failures++;
            $display("FAIL timeout_retry i=%0d got=%0d exp=%0d", i, bus.retry_count, er);
         end
         wait_pll_fall(n);
         checks++;
         if (n != P_RST) begin
            failures++;
            $display("FAIL timeout_pulse_len i=%0d got=%0d exp=%0d", i, n, P_RST);
         end
      end
   endtask

   task automatic test_button();
      int len;
      logic [1:0] es;
      do_por(2'b11);
      for (int i = 0; i < 2 + L_ST + H_C; i++) tick();
      // Short presses below the debounce window must be ignored.
      for (int rep = 0; rep < 3; rep++) begin
         len = $urandom_range(1, B_ST - 1);
         for (int t = 1; t <= 12; t++) begin
            bus.button_n = (t <= len) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (bus.state !== 2'd3) begin failures++; $display("FAIL btn_short rep=%0d t=%0d got=%0d exp=3", rep, t, bus.state); end
         end
      end
      // Long hold: one press 2 (sync) + B_ST + 1 cycles in, then no re-press.
      for (int t = 1; t <= 72; t++) begin
         bus.button_n = (t <= 60) ? 1'b0 : 1'b1;
         tick();
         es = (t < B_ST + 3) ? 2'd3 : por_state(t - (B_ST + 3));
         checks += 2;
         if (bus.state !== es) begin failures++; $display("FAIL btn_long_state t=%0d got=%0d exp=%0d", t, bus.state, es); end
         if (bus.sys_areset !== (es != 2'd3)) begin failures++; $display("FAIL btn_long_sys t=%0d got=%b exp=%b", t, bus.sys_areset, es != 2'd3); end
      end
      checks++;
      if (bus.reset_cause !== 4'b0100) begin failures++; $display("FAIL btn_cause got=%b exp=0100", bus.reset_cause); end
      // After release the button re-arms and a new press is taken.
      len = $urandom_range(B_ST, 2 * B_ST);
      for (int t = 1; t <= B_ST + 4; t++) begin
         bus.button_n = (t <= len) ? 1'b0 : 1'b1;
         tick();
         es = (t < B_ST + 3) ? 2'd3 : 2'd0;
         checks++;
         if (bus.state !== es) begin failures++; $display("FAIL btn_repress t=%0d got=%0d exp=%0d", t, bus.state, es); end
      end
      bus.button_n = 1'b1;
   endtask

   task automatic test_sw_and_lockloss();
      logic [1:0] es;
      logic [1:0] lk;
      int d;
      do_por(2'b11);
      for (int i = 0; i < 2 + L_ST + H_C; i++) tick();
      d = $urandom_range(0, 5);
      for (int i = 0; i < d; i++) tick();
      checks++;
      if (bus.state !== 2'd3) begin failures++; $display("FAIL sw_pre_state got=%0d exp=3", bus.state); end
      for (int t = 1; t <= H_C + 2; t++) begin
         bus.sw_reset_req = (t == 1);
         tick();
         es = (t <= H_C) ? 2'd2 : 2'd3;
         checks += 3;
         if (bus.state !== es) begin failures++; $display("FAIL sw_state t=%0d got=%0d exp=%0d", t, bus.state, es); end
         if (bus.pll_reset !== 1'b0) begin failures++; $display("FAIL sw_pll_reset t=%0d got=%b exp=0", t, bus.pll_reset); end
         if (bus.sys_areset !== (es != 2'd3)) begin failures++; $display("FAIL sw_sys t=%0d got=%b exp=%b", t, bus.sys_areset, es != 2'd3); end
      end
      bus.sw_reset_req = 1'b0;
      checks++;
      if (bus.reset_cause !== 4'b1000) begin failures++; $display("FAIL sw_cause got=%b exp=1000", bus.reset_cause); end
      // Lock loss reaches the FSM two cycles late; line the sw pulse up with it.
      lk = 2'($urandom_range(0, 2));
      bus.pll_locked = lk;
      tick();
      tick();
      checks++;
      if (bus.state !== 2'd3) begin failures++; $display("FAIL combo_pre_state got=%0d exp=3", bus.state); end
      bus.sw_reset_req = 1'b1;
      tick();
      bus.sw_reset_req = 1'b0;
      checks += 4;
      if (bus.state !== 2'd0) begin failures++; $display("FAIL combo_state got=%0d exp=0", bus.state); end
      if (bus.reset_cause !== 4'b1010) begin failures++; $display("FAIL combo_cause got=%b exp=1010", bus.reset_cause); end
      if (bus.pll_reset !== 1'b1) begin failures++; $display("FAIL combo_pll_reset got=%b exp=1", bus.pll_reset); end
      if (bus.sys_areset !== 1'b1) begin failures++; $display("FAIL combo_sys got=%b exp=1", bus.sys_areset); end
      bus.pll_locked = 2'b11;
   endtask

   task automatic test_async_areset();
      int n;
      do_por(2'b01);
      for (int t = 0; t < L_TO; t++) tick();
      bus.pll_locked = 2'b11;
      wait_pll_fall(n);
      for (int i = 0; i < 2 + L_ST + 2; i++) tick();
      checks += 2;
      if (bus.state !== 2'd2) begin failures++; $display("FAIL async_pre_state got=%0d exp=2", bus.state); end
      if (bus.retry_count !== 8'd1) begin failures++; $display("FAIL async_pre_retry got=%0d exp=1", bus.retry_count); end
      #2;
      areset = 1'b1;
      #1;
      checks += 5;
      if (bus.pll_reset !== 1'b1) begin failures++; $display("FAIL async_pll_reset got=%b exp=1", bus.pll_reset); end
      if (bus.sys_areset !== 1'b1) begin failures++; $display("FAIL async_sys got=%b exp=1", bus.sys_areset); end
      if (bus.state !== 2'd0) begin failures++; $display("FAIL async_state got=%0d exp=0", bus.state); end
      if (bus.retry_count !== 8'd0) begin failures++; $display("FAIL async_retry got=%0d exp=0", bus.retry_count); end
      if (bus.reset_cause !== 4'b0001) begin failures++; $display("FAIL async_cause got=%b exp=0001", bus.reset_cause); end
      @(negedge clock);
      tick();
      areset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_lock_chatter();
      test_lock_timeout();
      test_button();
      test_sw_and_lockloss();
      test_async_areset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
